fetch_queue: RTL
================

# fetch_queue

Instruction fetch stage with a prefetch buffer, sitting directly upstream of the ID stage. It keeps a word-addressed PC and issues requests to the instruction memory. Returned words are buffered together with their NPC and handed to decode through a valid/ready handshake. It also absorbs branch redirects from EX/MEM and stops fetching once a HLT has been fetched.

## Interface
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- AW, 10, instruction-memory word-address width
- clk1  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  AW  word address of request (PC[AW-1:0])
- imem_rdata  in  32  instruction word, valid the cycle after imem_req
- redirect  in  1  taken branch from EX/MEM; flush and refetch
- redirect_pc  in  32  branch target (word address)
- id_valid  out  1  head entry available to decode
- id_ready  in  1  decode accepts head this cycle
- id_ir  out  32  head instruction (0 when empty)
- id_npc  out  32  head NPC = fetch address + 1 (0 when empty)
- halted  out  1  HLT fetched; no further requests

## Operation
- State: pc (32b), queue of DEPTH entries {ir, npc}, rd/wr pointers, count (0..DEPTH), inflight flag with its address, halt_seen.
- Request rule (no redirect): imem_req = !halt_seen && (count + inflight < DEPTH). On request: imem_addr = pc[AW-1:0]; pc <= pc+1; inflight <= 1 with address captured; else inflight <= 0.
- Response: when inflight was set last cycle and there is no redirect this cycle, push {imem_rdata, inflight_addr+1}.
- HLT detect: pushed word with {ir[30],ir[14:12],ir[6:4]} == 7'b0111111 sets halt_seen. That word is still enqueued. Any response for a request issued in the same cycle is discarded. imem_req stays low afterwards.
- Pop: id_valid = (count != 0). When id_valid && id_ready, advance rd pointer. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over everything:
  - queue cleared (count=0, pointers=0)
  - response returning this cycle discarded
  - halt_seen cleared
  - imem_req=1 with imem_addr=redirect_pc[AW-1:0]
  - pc <= redirect_pc+1; inflight <= 1
- Pointers wrap modulo DEPTH. count never exceeds DEPTH because requests are gated by count+inflight.

## Timing
- Reset values: pc=0, count=0, pointers=0, inflight=0, halt_seen=0. Outputs: imem_req=0 while rst high, id_valid=0, id_ir=0, id_npc=0, halted=0. perf_flush_cnt=0 when configured.
- First request occurs in the first cycle after rst deasserts, at address 0.
- Request in cycle t → rdata sampled at the end of t+1 → id_valid from t+2. Fill-to-decode latency is 2 cycles.
- Steady state is one instruction per cycle once count ≥ 1 and id_ready is held high.
- Redirect in cycle r: id_valid=0 in cycle r+1; target instruction appears on id_ir in cycle r+2.
- Full queue with id_ready low: imem_req=0. After a pop, a request is issued the next cycle.
- Redirect and pop in the same cycle: the pop is ignored and the queue is cleared.
- rst asserted mid-operation clears all state immediately (asynchronous). Outputs return to reset values within the same cycle.

## Configuration
- FETCH_QUEUE_PERF_EN defined: adds output port perf_flush_cnt (16b). It increments on every redirect and saturates at 16'hFFFF.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then id_ready=1, imem holding 32'h0020fab3 at 0 and 32'h0151eb33 at 1 → id_valid first high 2 cycles after reset release. id_ir/id_npc sequence: 0020fab3/1, 0151eb33/2.
- id_ready=0 for 10 cycles → count saturates at 4, imem_req=0, no entry lost. Releasing id_ready drains npc 1,2,3,4 in order with no gap.
- Redirect to 15 while queue holds 3 entries → next cycle id_valid=0. Following cycle id_npc=16, and no pre-redirect instruction is ever presented.
- imem word 3 = HLT (7'b0111111 encoding) → HLT entry delivered with npc=4. halted=1, word 4 is never presented, imem_req stays 0.
- Redirect after halted=1 → halted=0 and fetch resumes at redirect_pc.
- rst pulse mid-stream with a full queue → id_valid=0 and imem_req=0 immediately. Restart from address 0. With FETCH_QUEUE_PERF_EN, perf_flush_cnt reads 0 after reset and 2 after two redirects.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a DEPTH-entry prefetch buffer.
// Issues word-addressed imem requests, buffers {ir, npc} pairs for decode,
// absorbs EX/MEM redirects and stops fetching after a HLT is enqueued.
// Optional: define FETCH_QUEUE_PERF_EN to add the perf_flush_cnt output.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic          clk1,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_ir,
    output logic [31:0]   id_npc,
    output logic          halted
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]   perf_flush_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   infl_addr_q, infl_addr_d;
    logic          halt_seen_q, halt_seen_d;

    logic [31:0]   ir_mem_q  [DEPTH];
    logic [31:0]   npc_mem_q [DEPTH];

    logic          req_c;
    logic [AW-1:0] addr_c;
    logic          push_c;
    logic          pop_c;
    logic          is_hlt_c;
    logic [31:0]   push_npc_c;
    logic [CW-1:0] occupancy_c;

    // Next-state logic: redirect overrides request, response, pop and halt.
    always_comb begin
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        infl_addr_d = infl_addr_q;
        halt_seen_d = halt_seen_q;
        req_c       = 1'b0;
        addr_c      = pc_q[AW-1:0];
        push_c      = 1'b0;
        pop_c       = 1'b0;
        push_npc_c  = infl_addr_q + 32'd1;
        is_hlt_c    = ({imem_rdata[30], imem_rdata[14:12], imem_rdata[6:4]} == 7'b0111111);
        occupancy_c = count_q + CW'(inflight_q);

        if (redirect) begin
            req_c       = 1'b1;
            addr_c      = redirect_pc[AW-1:0];
            pc_d        = redirect_pc + 32'd1;
            inflight_d  = 1'b1;
            infl_addr_d = redirect_pc;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            halt_seen_d = 1'b0;
        end else begin
            push_c = inflight_q;
            pop_c  = (count_q != '0) && id_ready;

            if (!halt_seen_q && (occupancy_c < CW'(DEPTH))) begin
                req_c       = 1'b1;
                pc_d        = pc_q + 32'd1;
                inflight_d  = 1'b1;
                infl_addr_d = pc_q;
            end else begin
                inflight_d  = 1'b0;
            end

            // A HLT being enqueued kills the request issued alongside it.
            if (push_c && is_hlt_c) begin
                halt_seen_d = 1'b1;
                inflight_d  = 1'b0;
            end

            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    // Queue storage; contents are only visible while count is non-zero.
    always_ff @(posedge clk1) begin
        if (push_c) begin
            ir_mem_q[wr_ptr_q]  <= imem_rdata;
            npc_mem_q[wr_ptr_q] <= push_npc_c;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Saturating redirect counter.
    always_comb begin
        perf_d = perf_q;
        if (redirect && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_flush_cnt = perf_q;
`endif

    assign imem_req  = req_c && !rst;
    assign imem_addr = addr_c;
    assign id_valid  = (count_q != '0);
    assign id_ir     = id_valid ? ir_mem_q[rd_ptr_q]  : '0;
    assign id_npc    = id_valid ? npc_mem_q[rd_ptr_q] : '0;
    assign halted    = halt_seen_q;

endmodule
